// File: rtl/modulation_player.sv
// rtl/modulation_player.sv - double-banked amplitude-modulation sequencer with glitch-free bank swap
// Define MODULATION_SYNC_EN to honour the SYNC restart pulse (and let it trigger a pending swap).
module modulation_player #(
    parameter  int DEPTH  = 32768,
    parameter  int WIDTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WADDR,
    input  logic [WIDTH-1:0]  WDATA,
    input  logic              EN,
    input  logic [15:0]       FREQ_DIV,
    input  logic [ADDR_W-1:0] CYCLE,
    input  logic              SWAP_REQ,
    input  logic              SYNC,
    output logic [WIDTH-1:0]  MOD,
    output logic [ADDR_W-1:0] IDX,
    output logic              ACTIVE_BANK,
    output logic              SWAP_PEND,
    output logic              SWAP_ACK
);

    logic [WIDTH-1:0]  r_mem [0:2*DEPTH-1];
    logic [WIDTH-1:0]  r_rd_data;
    logic [WIDTH-1:0]  r_mod;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_cycle_q;
    logic [15:0]       r_div_cnt;
    logic              r_active_bank;
    logic              r_swap_pend;
    logic              r_swap_ack;

    logic [15:0]       w_n;
    logic              w_tick;
    logic              w_boundary;
    logic              w_sync;
    logic              w_swap;

    assign w_n        = (FREQ_DIV == 16'd0) ? 16'd1 : FREQ_DIV;
    // >= rather than == so lowering FREQ_DIV below the running count ticks at once
    assign w_tick     = EN && (r_div_cnt >= (w_n - 16'd1));
    assign w_boundary = w_tick && (r_idx == r_cycle_q);

`ifdef MODULATION_SYNC_EN
    assign w_sync = SYNC;
`else
    assign w_sync = SYNC & 1'b0;
`endif

    assign w_swap = r_swap_pend && (w_boundary || !EN || w_sync);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_div_cnt     <= '0;
            r_idx         <= '0;
            r_cycle_q     <= '0;
            r_active_bank <= 1'b0;
            r_swap_pend   <= 1'b0;
            r_swap_ack    <= 1'b0;
            r_rd_data     <= '0;
            r_mod         <= '0;
        end else begin
            if (!EN || w_sync || w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 16'd1;
            end

            if (w_swap || w_sync) begin
                r_idx <= '0;
            end else if (w_tick) begin
                r_idx <= (r_idx == r_cycle_q) ? '0 : r_idx + 1'b1;
            end

            if (w_swap) begin
                r_active_bank <= ~r_active_bank;
                r_cycle_q     <= CYCLE;
            end

            // a request coinciding with a swap is absorbed by it
            r_swap_pend <= !w_swap && (r_swap_pend || SWAP_REQ);
            r_swap_ack  <= w_swap;

            r_rd_data <= r_mem[{r_active_bank, r_idx}];
            r_mod     <= r_rd_data;
        end
    end

    // Host writes use the pre-swap bank select, so a write in the swap cycle lands in the new active bank
    always_ff @(posedge CLK) begin
        if (WE) begin
            r_mem[{~r_active_bank, WADDR}] <= WDATA;
        end
    end

    assign MOD         = r_mod;
    assign IDX         = r_idx;
    assign ACTIVE_BANK = r_active_bank;
    assign SWAP_PEND   = r_swap_pend;
    assign SWAP_ACK    = r_swap_ack;

endmodule

// File: tb/tb_modulation_player.sv
// tb/tb_modulation_player.sv - directed self-checking bench for modulation_player (DEPTH=16, WIDTH=8)
module tb_modulation_player;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WE = 1'b0;
    logic [3:0] WADDR = '0;
    logic [7:0] WDATA = '0;
    logic       EN = 1'b0;
    logic [15:0] FREQ_DIV = '0;
    logic [3:0] CYCLE = '0;
    logic       SWAP_REQ = 1'b0;
    logic       SYNC = 1'b0;
    logic [7:0] MOD;
    logic [3:0] IDX;
    logic       ACTIVE_BANK;
    logic       SWAP_PEND;
    logic       SWAP_ACK;

    int errors = 0;
    int checks = 0;

    modulation_player #(.DEPTH(16), .WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .EN(EN),
        .FREQ_DIV(FREQ_DIV), .CYCLE(CYCLE), .SWAP_REQ(SWAP_REQ), .SYNC(SYNC),
        .MOD(MOD), .IDX(IDX), .ACTIVE_BANK(ACTIVE_BANK), .SWAP_PEND(SWAP_PEND), .SWAP_ACK(SWAP_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++; if (MOD !== 8'd0) begin errors++; $display("FAIL reset_mod: got %0d want 0", MOD); end
        checks++; if (IDX !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", IDX); end
        checks++; if (ACTIVE_BANK !== 1'b0) begin errors++; $display("FAIL reset_bank: got %0d want 0", ACTIVE_BANK); end
        checks++; if (SWAP_PEND !== 1'b0) begin errors++; $display("FAIL reset_pend: got %0d want 0", SWAP_PEND); end
        checks++; if (SWAP_ACK !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0d want 0", SWAP_ACK); end
        RST = 1'b0;
        step();
    endtask

    task automatic test_static_playback();
        logic [3:0] e_idx;
        logic [7:0] e_mod;
        for (int i = 0; i < 4; i++) begin
            WE = 1'b1; WADDR = 4'(i); WDATA = 8'(10 * (i + 1));
            step();
        end
        WE = 1'b0;
        CYCLE = 4'd3; SWAP_REQ = 1'b1;
        step();
        SWAP_REQ = 1'b0;
        checks++; if (SWAP_PEND !== 1'b1) begin errors++; $display("FAIL static_pend: got %0d want 1", SWAP_PEND); end
        step();
        checks++; if (SWAP_ACK !== 1'b1) begin errors++; $display("FAIL static_ack: got %0d want 1", SWAP_ACK); end
        checks++; if (ACTIVE_BANK !== 1'b1) begin errors++; $display("FAIL static_bank: got %0d want 1", ACTIVE_BANK); end
        checks++; if (SWAP_PEND !== 1'b0) begin errors++; $display("FAIL static_pend_clr: got %0d want 0", SWAP_PEND); end
        step();
        checks++; if (SWAP_ACK !== 1'b0) begin errors++; $display("FAIL static_ack_pulse: got %0d want 0", SWAP_ACK); end
        EN = 1'b1; FREQ_DIV = 16'd4;
        for (int k = 1; k <= 24; k++) begin
            step();
            e_idx = 4'((k / 4) % 4);
            checks++; if (IDX !== e_idx) begin errors++; $display("FAIL static_idx k=%0d: got %0d want %0d", k, IDX, e_idx); end
            if (k >= 2) begin
                e_mod = 8'(10 * (((k - 2) / 4) % 4 + 1));
                checks++; if (MOD !== e_mod) begin errors++; $display("FAIL static_mod k=%0d: got %0d want %0d", k, MOD, e_mod); end
            end
        end
    endtask

    task automatic test_glitch_free_swap();
        int n;
        for (int i = 0; i < 8; i++) begin
            WE = 1'b1; WADDR = 4'(i); WDATA = 8'hAA;
            step();
        end
        WE = 1'b0;
        n = 0;
        while (IDX != 4'd1 && n < 40) begin
            step();
            n++;
        end
        checks++; if (IDX !== 4'd1) begin errors++; $display("FAIL glitch_wait_idx1: got %0d want 1", IDX); end
        SWAP_REQ = 1'b1; CYCLE = 4'd7;
        for (int j = 1; j <= 45; j++) begin
            step();
            SWAP_REQ = 1'b0;
            if (j <= 11) begin
                checks++; if (SWAP_PEND !== 1'b1) begin errors++; $display("FAIL glitch_pend j=%0d: got %0d want 1", j, SWAP_PEND); end
                checks++; if (ACTIVE_BANK !== 1'b1) begin errors++; $display("FAIL glitch_bank_old j=%0d: got %0d want 1", j, ACTIVE_BANK); end
            end
            if (j == 4) begin
                checks++; if (IDX !== 4'd2) begin errors++; $display("FAIL glitch_idx2: got %0d want 2", IDX); end
            end
            if (j == 8) begin
                checks++; if (IDX !== 4'd3) begin errors++; $display("FAIL glitch_idx3: got %0d want 3", IDX); end
            end
            if (j == 11) begin
                checks++; if (SWAP_ACK !== 1'b0) begin errors++; $display("FAIL glitch_ack_early: got %0d want 0", SWAP_ACK); end
            end
            if (j == 12) begin
                checks++; if (SWAP_ACK !== 1'b1) begin errors++; $display("FAIL glitch_ack: got %0d want 1", SWAP_ACK); end
                checks++; if (ACTIVE_BANK !== 1'b0) begin errors++; $display("FAIL glitch_bank_new: got %0d want 0", ACTIVE_BANK); end
                checks++; if (SWAP_PEND !== 1'b0) begin errors++; $display("FAIL glitch_pend_clr: got %0d want 0", SWAP_PEND); end
                checks++; if (IDX !== 4'd0) begin errors++; $display("FAIL glitch_idx0: got %0d want 0", IDX); end
            end
            if (j == 13) begin
                checks++; if (MOD !== 8'd40) begin errors++; $display("FAIL glitch_last_old: got %0d want 40", MOD); end
            end
            if (j >= 14) begin
                checks++; if (MOD !== 8'hAA) begin errors++; $display("FAIL glitch_mod j=%0d: got %0h want aa", j, MOD); end
            end
            if (j == 16) begin
                checks++; if (IDX !== 4'd1) begin errors++; $display("FAIL glitch_new_idx1: got %0d want 1", IDX); end
            end
            if (j == 44) begin
                checks++; if (IDX !== 4'd0) begin errors++; $display("FAIL glitch_wrap7: got %0d want 0", IDX); end
            end
        end
    endtask

    task automatic test_divider();
        logic [3:0] e_idx;
        logic [3:0] exp_slow [5];
        FREQ_DIV = 16'd1;
        for (int k = 1; k <= 4; k++) begin
            step();
            e_idx = 4'(k);
            checks++; if (IDX !== e_idx) begin errors++; $display("FAIL div1_idx k=%0d: got %0d want %0d", k, IDX, e_idx); end
        end
        FREQ_DIV = 16'd0;
        for (int k = 1; k <= 4; k++) begin
            step();
            e_idx = 4'((4 + k) % 8);
            checks++; if (IDX !== e_idx) begin errors++; $display("FAIL div0_idx k=%0d: got %0d want %0d", k, IDX, e_idx); end
        end
        FREQ_DIV = 16'd100;
        for (int k = 0; k < 50; k++) step();
        checks++; if (IDX !== 4'd0) begin errors++; $display("FAIL div100_hold: got %0d want 0", IDX); end
        FREQ_DIV = 16'd2;
        exp_slow = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (IDX !== exp_slow[k]) begin errors++; $display("FAIL div_lowered k=%0d: got %0d want %0d", k, IDX, exp_slow[k]); end
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp_mod [3];
        EN = 1'b0; SWAP_REQ = 1'b1; CYCLE = 4'd3;
        step();
        checks++; if (SWAP_PEND !== 1'b1) begin errors++; $display("FAIL sim_pend: got %0d want 1", SWAP_PEND); end
        WE = 1'b1; WADDR = 4'd1; WDATA = 8'h55;
        step();
        WE = 1'b0; SWAP_REQ = 1'b0;
        checks++; if (SWAP_ACK !== 1'b1) begin errors++; $display("FAIL sim_ack: got %0d want 1", SWAP_ACK); end
        checks++; if (ACTIVE_BANK !== 1'b1) begin errors++; $display("FAIL sim_bank: got %0d want 1", ACTIVE_BANK); end
        checks++; if (SWAP_PEND !== 1'b0) begin errors++; $display("FAIL sim_req_consumed: got %0d want 0", SWAP_PEND); end
        step();
        checks++; if (SWAP_PEND !== 1'b0) begin errors++; $display("FAIL sim_pend_stays0: got %0d want 0", SWAP_PEND); end
        checks++; if (SWAP_ACK !== 1'b0) begin errors++; $display("FAIL sim_ack_pulse: got %0d want 0", SWAP_ACK); end
        EN = 1'b1; FREQ_DIV = 16'd1;
        exp_mod = '{8'd10, 8'h55, 8'd30};
        step();
        for (int k = 2; k <= 4; k++) begin
            step();
            checks++; if (MOD !== exp_mod[k-2]) begin errors++; $display("FAIL sim_mod k=%0d: got %0h want %0h", k, MOD, exp_mod[k-2]); end
        end
    endtask

    task automatic test_sync();
        step();
        step();
        checks++; if (IDX !== 4'd2) begin errors++; $display("FAIL sync_setup_idx: got %0d want 2", IDX); end
        FREQ_DIV = 16'd4; SWAP_REQ = 1'b1; CYCLE = 4'd5;
        step();
        SWAP_REQ = 1'b0;
        checks++; if (SWAP_PEND !== 1'b1) begin errors++; $display("FAIL sync_pend: got %0d want 1", SWAP_PEND); end
        SYNC = 1'b1;
        step();
        SYNC = 1'b0;
`ifdef MODULATION_SYNC_EN
        checks++; if (IDX !== 4'd0) begin errors++; $display("FAIL sync_idx: got %0d want 0", IDX); end
        checks++; if (SWAP_ACK !== 1'b1) begin errors++; $display("FAIL sync_ack: got %0d want 1", SWAP_ACK); end
        checks++; if (ACTIVE_BANK !== 1'b0) begin errors++; $display("FAIL sync_bank: got %0d want 0", ACTIVE_BANK); end
        checks++; if (SWAP_PEND !== 1'b0) begin errors++; $display("FAIL sync_pend_clr: got %0d want 0", SWAP_PEND); end
        for (int k = 0; k < 4; k++) step();
        checks++; if (IDX !== 4'd1) begin errors++; $display("FAIL sync_div_restart: got %0d want 1", IDX); end
`else
        checks++; if (IDX !== 4'd2) begin errors++; $display("FAIL nosync_idx: got %0d want 2", IDX); end
        checks++; if (SWAP_ACK !== 1'b0) begin errors++; $display("FAIL nosync_ack: got %0d want 0", SWAP_ACK); end
        checks++; if (ACTIVE_BANK !== 1'b1) begin errors++; $display("FAIL nosync_bank: got %0d want 1", ACTIVE_BANK); end
        checks++; if (SWAP_PEND !== 1'b1) begin errors++; $display("FAIL nosync_pend: got %0d want 1", SWAP_PEND); end
        for (int k = 0; k < 4; k++) step();
        checks++; if (IDX !== 4'd3) begin errors++; $display("FAIL nosync_div_kept: got %0d want 3", IDX); end
`endif
    endtask

    task automatic test_reset_mid();
        EN = 1'b0;
        step();
        SWAP_REQ = 1'b1; CYCLE = 4'd7;
        step();
        SWAP_REQ = 1'b0;
        step();
        checks++; if (ACTIVE_BANK !== 1'b1) begin errors++; $display("FAIL rmid_setup_bank: got %0d want 1", ACTIVE_BANK); end
        EN = 1'b1; FREQ_DIV = 16'd1;
        for (int k = 0; k < 4; k++) step();
        SWAP_REQ = 1'b1;
        step();
        SWAP_REQ = 1'b0;
        checks++; if (IDX !== 4'd5) begin errors++; $display("FAIL rmid_idx5: got %0d want 5", IDX); end
        checks++; if (SWAP_PEND !== 1'b1) begin errors++; $display("FAIL rmid_pend: got %0d want 1", SWAP_PEND); end
        RST = 1'b1;
        #1;
        checks++; if (MOD !== 8'd0) begin errors++; $display("FAIL rmid_async_mod: got %0d want 0", MOD); end
        checks++; if (IDX !== 4'd0) begin errors++; $display("FAIL rmid_async_idx: got %0d want 0", IDX); end
        checks++; if (ACTIVE_BANK !== 1'b0) begin errors++; $display("FAIL rmid_async_bank: got %0d want 0", ACTIVE_BANK); end
        checks++; if (SWAP_PEND !== 1'b0) begin errors++; $display("FAIL rmid_async_pend: got %0d want 0", SWAP_PEND); end
        checks++; if (SWAP_ACK !== 1'b0) begin errors++; $display("FAIL rmid_async_ack: got %0d want 0", SWAP_ACK); end
        step();
        RST = 1'b0;
        for (int k = 0; k < 3; k++) step();
        checks++; if (IDX !== 4'd0) begin errors++; $display("FAIL rmid_post_idx: got %0d want 0", IDX); end
        checks++; if (ACTIVE_BANK !== 1'b0) begin errors++; $display("FAIL rmid_post_bank: got %0d want 0", ACTIVE_BANK); end
        checks++; if (SWAP_PEND !== 1'b0) begin errors++; $display("FAIL rmid_post_pend: got %0d want 0", SWAP_PEND); end
        checks++; if (SWAP_ACK !== 1'b0) begin errors++; $display("FAIL rmid_post_ack: got %0d want 0", SWAP_ACK); end
        checks++; if (MOD !== 8'hAA) begin errors++; $display("FAIL rmid_post_mod: got %0h want aa", MOD); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_static_playback();
        test_glitch_free_swap();
        test_divider();
        test_simultaneous();
        test_sync();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modulation_player.md
# modulation_player

Parametrised, double-banked amplitude-modulation sequencer. The host writes a pattern of up to DEPTH samples into the shadow bank while the active bank is played back at a programmable sample rate. The bank swap happens only on a pattern boundary, so playback never glitches. MOD feeds the duty/amplitude path of every transducer channel.

## Interface
- DEPTH, 32768 — samples per bank; must be a power of two; ADDR_W = $clog2(DEPTH) (localparam)
- WIDTH, 8 — sample width in bits
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- WE  in  1  host write strobe; writes always target the shadow bank
- WADDR  in  ADDR_W  host write address
- WDATA  in  WIDTH  host write data
- EN  in  1  playback enable
- FREQ_DIV  in  16  CLK cycles per sample, N = max(FREQ_DIV, 1); sampled every cycle
- CYCLE  in  ADDR_W  last index of the new pattern (length = CYCLE+1); latched at swap
- SWAP_REQ  in  1  request a bank swap at the next pattern boundary
- SYNC  in  1  restart pulse (see Configuration)
- MOD  out  WIDTH  current sample, registered
- IDX  out  ADDR_W  current playback index
- ACTIVE_BANK  out  1  bank being played
- SWAP_PEND  out  1  swap requested, not yet taken
- SWAP_ACK  out  1  one-cycle pulse in the cycle the swap takes effect

## Operation
- Memory: 2×DEPTH×WIDTH simple dual-port RAM. Write port address is {~ACTIVE_BANK, WADDR}. Read port address is {ACTIVE_BANK, IDX}.
- Divider: div_cnt counts 0..N-1. tick = EN && (div_cnt >= N-1), and tick resets div_cnt to 0. When N is lowered below div_cnt, the next cycle ticks. With EN low, div_cnt is held at 0.
- Index: on tick, IDX = (IDX == cycle_q) ? 0 : IDX+1. That transition from cycle_q to 0 is the pattern boundary. With EN low, IDX is held at its current value.
- Swap: SWAP_REQ sets SWAP_PEND. Repeated requests are idempotent. A swap executes on the first of the following events while pending:
  - a boundary tick;
  - any cycle with EN low;
  - a SYNC pulse.
- A swap does all of the following in the same cycle: toggles ACTIVE_BANK, latches cycle_q = CYCLE, forces IDX = 0, clears SWAP_PEND and pulses SWAP_ACK.
- A SWAP_REQ in the same cycle as a swap is consumed by that swap. It does not queue a second one.
- A write in the same cycle as a swap goes to the pre-swap shadow bank, which becomes the newly active bank.
- SYNC (when compiled in) sets div_cnt = 0 and IDX = 0. SYNC overrides a simultaneous tick.

## Timing
- Reset values: MOD=0, IDX=0, ACTIVE_BANK=0, SWAP_PEND=0, SWAP_ACK=0, cycle_q=0, div_cnt=0. RAM contents are not cleared.
- Reset mid-operation: a pending swap is discarded. After RST deasserts, playback restarts from bank 0, index 0.
- Read latency: the IDX value registered in cycle t appears on MOD in cycle t+2 (RAM read plus output register).
- Write-to-visibility: a write to the shadow bank is readable only after the swap that activates it. Writes never alter the active bank.
- Sample period: once EN rises, the first tick occurs N cycles later, and every subsequent tick N cycles after the previous one.

## Configuration
- MODULATION_SYNC_EN defined:
  - SYNC acts as described above.
  - A pending swap also executes on SYNC, so multiple devices restart on an identical pattern.
- Undefined:
  - SYNC is ignored; the port remains on the interface and its logic is optimised away.
  - A swap occurs only on a boundary tick or with EN low.

## Test plan
- Reset and static playback: write 0..3 → 10,20,30,40 into bank 1; SWAP_REQ with EN=0, CYCLE=3; then EN=1, FREQ_DIV=4 → SWAP_ACK one cycle, ACTIVE_BANK=1; MOD sequence 10,20,30,40,10… with each value held 4 cycles, 2 cycles after IDX.
- Glitch-free swap: playing bank 1 with CYCLE=3; load bank 0 with 0xAA×8; SWAP_REQ at IDX=1 with CYCLE=7 → IDX continues 2,3; swap on the 3→0 tick; then MOD=0xAA for 8 samples; SWAP_PEND high from request until ACK.
- Divider edge cases: FREQ_DIV=0 and 1 → tick every cycle. FREQ_DIV changed from 100 to 2 while div_cnt=50 → tick next cycle, then every 2 cycles.
- Simultaneous events: WE and swap in the same cycle → the data appears in the new active bank. SWAP_REQ during the ACK cycle → SWAP_PEND stays 0.
- SYNC (with MODULATION_SYNC_EN): pulse at IDX=2 with a swap pending → next cycle IDX=0, div_cnt=0, SWAP_ACK=1. Without the macro, the same stimulus → no change.
- Reset mid-operation: assert RST at IDX=5 with SWAP_PEND=1 → all outputs go to 0 asynchronously. After release with EN=1, playback runs from bank 0, index 0, with SWAP_PEND=0.
